// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU. It decodes the ALU control code,
// selects the second operand, and inserts a bubble on a load-use hazard.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall_ext,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs2,
  input  logic [1:0]        id_alu_op,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_mem_to_reg,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_in1,
  output logic [XLEN-1:0]   ex_in2,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [3:0]        ex_alu_control,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal
);

  logic [3:0] alu_control;
  logic       illegal;

  // Anything not explicitly decoded is flagged illegal and gets the 1111 code.
  always_comb begin
    alu_control = 4'b1111;
    illegal     = 1'b1;
    case (id_alu_op)
      2'b00: begin
        alu_control = 4'b0010;
        illegal     = 1'b0;
      end
      2'b01: begin
        alu_control = 4'b0110;
        illegal     = 1'b0;
      end
      2'b10: begin
        case (id_funct3)
          3'b000: begin
            alu_control = id_funct7_5 ? 4'b0110 : 4'b0010;
            illegal     = 1'b0;
          end
          3'b111: begin
            alu_control = 4'b0000;
            illegal     = 1'b0;
          end
          3'b110: begin
            alu_control = 4'b0001;
            illegal     = 1'b0;
          end
          default: begin
            alu_control = 4'b1111;
            illegal     = 1'b1;
          end
        endcase
      end
      default: begin
        case (id_funct3)
          3'b000: begin
            alu_control = 4'b0010;
            illegal     = 1'b0;
          end
          3'b111: begin
            alu_control = 4'b0000;
            illegal     = 1'b0;
          end
          3'b110: begin
            alu_control = 4'b0001;
            illegal     = 1'b0;
          end
          default: begin
            alu_control = 4'b1111;
            illegal     = 1'b1;
          end
        endcase
      end
    endcase
  end

  // x0 is never a real producer, so a load to rd=0 cannot cause a hazard.
  assign hazard_stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                        ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // Flush and bubble clear only the control state; data fields keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_in1         <= '0;
      ex_in2         <= '0;
      ex_store_data  <= '0;
      ex_alu_control <= 4'b0000;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_illegal     <= 1'b0;
    end else if (flush || (!stall_ext && hazard_stall)) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!stall_ext) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_in1         <= id_rs1_data;
      ex_in2         <= id_alu_src ? id_imm : id_rs2_data;
      ex_store_data  <= id_rs2_data;
      ex_alu_control <= alu_control;
      ex_rd          <= id_rd;
      ex_reg_write   <= id_valid & id_reg_write & ~illegal;
      ex_mem_read    <= id_valid & id_mem_read;
      ex_mem_write   <= id_valid & id_mem_write & ~illegal;
      ex_branch      <= id_valid & id_branch;
      ex_mem_to_reg  <= id_valid & id_mem_to_reg;
      ex_illegal     <= id_valid & illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed EX state per
// cycle, a negedge monitor pops and compares it against the DUT.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u2;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7, src, rw, mr, mw, br, m2r;
  } id_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, in1, in2, sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, m2r, ill;
    bit          chk_data, chk_ctrl;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall_ext;
  logic        id_valid, id_uses_rs2, id_funct7_5, id_alu_src;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_in1, ex_in2, ex_store_data;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_illegal;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t m;
  exp_t e;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall_ext(stall_ext),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_alu_op(id_alu_op),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_in1(ex_in1),
    .ex_in2(ex_in2), .ex_store_data(ex_store_data), .ex_alu_control(ex_alu_control),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ex_valid"}, 32'(ex_valid), 0);
    check({tag, " ex_pc"}, ex_pc, 0);
    check({tag, " ex_in1"}, ex_in1, 0);
    check({tag, " ex_in2"}, ex_in2, 0);
    check({tag, " ex_store_data"}, ex_store_data, 0);
    check({tag, " ex_alu_control"}, 32'(ex_alu_control), 0);
    check({tag, " ex_rd"}, 32'(ex_rd), 0);
    check({tag, " ex_ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write,
                                 ex_branch, ex_mem_to_reg, ex_illegal}), 0);
  endtask

  function automatic id_t rtype(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [31:0] d1, logic [31:0] d2,
                                logic [2:0] f3, logic f7);
    id_t i = '{default: 0};
    i.valid = 1; i.pc = pc; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.d1 = d1; i.d2 = d2;
    i.u2 = 1; i.op = 2'b10; i.f3 = f3; i.f7 = f7; i.rw = 1;
    return i;
  endfunction

  function automatic id_t ialu(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [31:0] d1, logic [31:0] d2,
                               logic [31:0] imm, logic [2:0] f3);
    id_t i = '{default: 0};
    i.valid = 1; i.pc = pc; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.d1 = d1; i.d2 = d2;
    i.imm = imm; i.op = 2'b11; i.f3 = f3; i.src = 1; i.rw = 1;
    return i;
  endfunction

  function automatic id_t load(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                               logic [31:0] d1, logic [31:0] imm);
    id_t i = '{default: 0};
    i.valid = 1; i.pc = pc; i.rd = rd; i.rs1 = rs1; i.d1 = d1; i.imm = imm;
    i.op = 2'b00; i.f3 = 3'b010; i.src = 1; i.rw = 1; i.mr = 1; i.m2r = 1;
    return i;
  endfunction

  function automatic id_t store(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] d1, logic [31:0] d2, logic [31:0] imm);
    id_t i = '{default: 0};
    i.valid = 1; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.d1 = d1; i.d2 = d2; i.imm = imm;
    i.u2 = 1; i.op = 2'b00; i.f3 = 3'b010; i.src = 1; i.mw = 1;
    return i;
  endfunction

  function automatic id_t branch(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [31:0] d1, logic [31:0] d2, logic [31:0] imm);
    id_t i = '{default: 0};
    i.valid = 1; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.d1 = d1; i.d2 = d2; i.imm = imm;
    i.u2 = 1; i.op = 2'b01; i.f3 = 3'b000; i.br = 1;
    return i;
  endfunction

  // Drive one ID vector plus hand-decoded expectations; push the EX state due next cycle.
  task automatic issue(input id_t i, input logic [3:0] ectrl, input logic eill,
                       input logic ehaz, input logic fl, input logic st);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    id_valid = i.valid; id_pc = i.pc; id_rs1_data = i.d1; id_rs2_data = i.d2;
    id_imm = i.imm; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_uses_rs2 = i.u2;
    id_alu_op = i.op; id_funct3 = i.f3; id_funct7_5 = i.f7; id_alu_src = i.src;
    id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
    id_branch = i.br; id_mem_to_reg = i.m2r;
    flush = fl;
    stall_ext = st;
    #1;
    check("hazard_stall", 32'(hazard_stall), 32'(ehaz));
    if (fl || (!st && ehaz)) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0; m.m2r = 0; m.ill = 0;
      m.chk_data = 0; m.chk_ctrl = 0;
    end else if (!st) begin
      m.valid = i.valid; m.pc = i.pc; m.in1 = i.d1; m.in2 = i.src ? i.imm : i.d2;
      m.sd = i.d2; m.rd = i.rd; m.ctrl = ectrl;
      m.chk_data = 1; m.chk_ctrl = i.valid;
      m.rw  = i.valid & i.rw & ~eill;
      m.mw  = i.valid & i.mw & ~eill;
      m.mr  = i.valid & i.mr;
      m.br  = i.valid & i.br;
      m.m2r = i.valid & i.m2r;
      m.ill = i.valid & eill;
    end
    m.cycle = cyc + 1;
    sb.push_back(m);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0 && sb[0].cycle == cyc) begin
      e = sb.pop_front();
      check("ex_valid", 32'(ex_valid), 32'(e.valid));
      check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
      check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
      check("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
      check("ex_branch", 32'(ex_branch), 32'(e.br));
      check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
      check("ex_illegal", 32'(ex_illegal), 32'(e.ill));
      if (e.chk_ctrl) check("ex_alu_control", 32'(ex_alu_control), 32'(e.ctrl));
      if (e.chk_data) begin
        check("ex_pc", ex_pc, e.pc);
        check("ex_in1", ex_in1, e.in1);
        check("ex_in2", ex_in2, e.in2);
        check("ex_store_data", ex_store_data, e.sd);
        check("ex_rd", 32'(ex_rd), 32'(e.rd));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected finish", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    id_t v;
    rst_n = 1'b0; flush = 0; stall_ext = 0;
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs2 = 0; id_alu_op = 0;
    id_funct3 = 0; id_funct7_5 = 0; id_alu_src = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_mem_to_reg = 0;
    m = '{default: 0};
    m.chk_data = 1; m.chk_ctrl = 1;
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    $display("[TB] decode sweep");
    issue(rtype(32'h100, 3, 1, 2, 5, 7, 3'b000, 0), 4'b0010, 0, 0, 0, 0);
    issue(rtype(32'h104, 6, 1, 2, 20, 3, 3'b000, 1), 4'b0110, 0, 0, 0, 0);
    issue(ialu(32'h108, 7, 1, 0, 32'h1234, 32'h55, 32'hF0, 3'b111), 4'b0000, 0, 0, 0, 0);
    issue(ialu(32'h10C, 8, 2, 0, 32'hA, 0, 32'h3, 3'b110), 4'b0001, 0, 0, 0, 0);
    issue(branch(32'h110, 1, 2, 9, 9, 32'h40), 4'b0110, 0, 0, 0, 0);
    issue(load(32'h114, 4, 1, 32'h1000, 8), 4'b0010, 0, 0, 0, 0);
    $display("[TB] load-use");
    issue(rtype(32'h118, 5, 4, 1, 32'hAA, 32'hBB, 3'b000, 0), 4'b0010, 0, 1, 0, 0);
    issue(rtype(32'h118, 5, 4, 1, 32'hAA, 32'hBB, 3'b000, 0), 4'b0010, 0, 0, 0, 0);
    issue(load(32'h11C, 0, 1, 32'h2000, 4), 4'b0010, 0, 0, 0, 0);
    issue(rtype(32'h120, 5, 0, 1, 0, 6, 3'b000, 0), 4'b0010, 0, 0, 0, 0);
    issue(load(32'h124, 4, 2, 32'h3000, 12), 4'b0010, 0, 0, 0, 0);
    issue(ialu(32'h128, 8, 1, 4, 32'h11, 32'h22, 32'h5, 3'b000), 4'b0010, 0, 0, 0, 0);
    issue(rtype(32'h12C, 9, 1, 2, 1, 2, 3'b001, 0), 4'b1111, 1, 0, 0, 0);
    $display("[TB] flush priority");
    issue(load(32'h130, 4, 1, 32'h100, 0), 4'b0010, 0, 0, 0, 0);
    issue(store(32'h134, 1, 4, 32'h50, 32'h60, 0), 4'b0010, 0, 1, 1, 1);
    $display("[TB] hazard under external stall");
    issue(load(32'h138, 9, 1, 32'h400, 16), 4'b0010, 0, 0, 0, 0);
    issue(rtype(32'h13C, 10, 9, 2, 1, 2, 3'b000, 0), 4'b0010, 0, 1, 0, 1);
    issue(rtype(32'h13C, 10, 9, 2, 1, 2, 3'b000, 0), 4'b0010, 0, 1, 0, 1);
    issue(rtype(32'h13C, 10, 9, 2, 1, 2, 3'b000, 0), 4'b0010, 0, 1, 0, 0);
    issue(rtype(32'h13C, 10, 9, 2, 1, 2, 3'b000, 0), 4'b0010, 0, 0, 0, 0);
    $display("[TB] external stall hold");
    issue(ialu(32'h140, 11, 3, 0, 7, 8, 32'h9, 3'b110), 4'b0001, 0, 0, 0, 1);
    issue(rtype(32'h144, 12, 3, 4, 30, 10, 3'b000, 1), 4'b0110, 0, 0, 0, 1);
    issue(ialu(32'h148, 13, 5, 0, 32'hFF, 1, 32'h0F, 3'b111), 4'b0000, 0, 0, 0, 1);
    issue(ialu(32'h148, 13, 5, 0, 32'hFF, 1, 32'h0F, 3'b111), 4'b0000, 0, 0, 0, 0);
    v = rtype(32'h14C, 14, 1, 2, 3, 4, 3'b000, 0);
    v.valid = 0;
    issue(v, 4'b0010, 0, 0, 0, 0);
    $display("[TB] reset mid-stream");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    m = '{default: 0};
    m.chk_data = 1; m.chk_ctrl = 1;
    issue(rtype(32'h200, 3, 1, 2, 5, 7, 3'b000, 0), 4'b0010, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU.
- Latches decoded operands and control signals from ID and derives the 4-bit ALU control code from alu_op/funct3/funct7_5.
- Selects the second ALU operand (register or immediate).
- Detects load-use hazards, inserts a bubble and honours external stall and flush.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch/jump redirect; kill the instruction entering EX
- stall_ext  in  1  downstream stall; hold all EX registers
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices
- id_uses_rs2  in  1  instruction reads rs2
- id_alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3  in  3  instruction funct3
- id_funct7_5  in  1  instruction bit 30
- id_alu_src  in  1  1: in2 = imm, 0: in2 = rs2_data
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg  in  1 each  control bits
- hazard_stall  out  1  combinational; ID/IF must hold this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_in1, ex_in2, ex_store_data  out  XLEN  ALU operands and store data (rs2_data)
- ex_alu_control  out  4  ALU opcode
- ex_rd  out  REG_AW  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg  out  1 each  control bits
- ex_illegal  out  1  unsupported alu_op/funct combination

Behaviour:
- Clock and reset: clk, rst_n; asynchronous active-low reset.
- Reset value of every registered output is 0, including ex_valid and ex_alu_control = 4'b0000.
- ALU control decode (combinational on ID inputs, then registered):
  - alu_op 00 -> 0010 (ADD).
  - alu_op 01 -> 0110 (SUB).
  - alu_op 10: funct3 000 with f7_5=0 -> 0010; funct3 000 with f7_5=1 -> 0110; funct3 111 -> 0000; funct3 110 -> 0001.
  - alu_op 11: funct3 000 -> 0010 (funct7_5 ignored); funct3 111 -> 0000; funct3 110 -> 0001.
  - Any other combination -> 1111 with ex_illegal=1 and reg_write/mem_write forced 0.
- Operands: ex_in1 = rs1_data. ex_in2 = alu_src ? imm : rs2_data. ex_store_data = rs2_data always.
- hazard_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- Per-edge update, highest priority first:
  1. flush: ex_valid <= 0 and all control bits <= 0; data fields don't-care (hold).
  2. stall_ext: hold every register.
  3. hazard_stall: insert bubble. ex_valid <= 0, control bits <= 0, ID inputs not captured (upstream holds).
  4. Otherwise capture ID inputs. ex_valid <= id_valid. When id_valid=0, control bits are captured as 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Bubble rule: ex_valid=0 guarantees reg_write, mem_read, mem_write, branch and illegal are all 0.
- hazard_stall while stall_ext=1: hold takes precedence, no bubble. hazard_stall stays asserted until the load leaves EX.
- Reset mid-operation clears immediately, without waiting for clk. After rst_n rises, the first capture occurs on the next edge.
- Register x0: rd=0 never causes a hazard.

Test Plan:
- Reset: rst_n=0 mid-stream -> all ex_* = 0 immediately; release, drive ADD x3,x1,x2 (rs1=5, rs2=7, alu_op 10, f3 000, f7_5 0) -> next cycle ex_alu_control=0010, ex_in1=5, ex_in2=7, ex_valid=1.
- Decode sweep:
  - SUB (10/000/1) -> 0110.
  - ANDI (11/111, imm=0xF0, alu_src=1) -> 0000, ex_in2=0xF0.
  - ORI -> 0001.
  - BEQ (01) -> 0110.
  - LW (00) -> 0010.
  - R-type funct3 001 -> 1111, ex_illegal=1, ex_reg_write=0.
- Load-use:
  - LW x4 in EX, ID ADD x5,x4,x1 -> hazard_stall=1 and next cycle ex_valid=0 (bubble); then the ADD captures.
  - Same with rd=x0 -> hazard_stall=0.
  - With id_uses_rs2=0 and rs2 match -> no stall.
- Flush priority: flush=1 with stall_ext=1 and hazard_stall=1 -> ex_valid=0, ex_mem_write=0 next edge.
- stall_ext held 3 cycles with changing ID inputs -> ex_* unchanged throughout; release -> current ID values captured next edge.
